// File: rtl/if_fetch.sv
// Instruction fetch unit: in-order word reads over req/gnt/rvalid, a small
// instruction buffer with same-edge bypass, and redirect with squash of stale reads.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_r;
  logic [31:0]     fpc_r;
  logic [31:0]     rpc_r;
  logic [31:0]     buf_inst_r [FIFO_DEPTH];
  logic [31:0]     buf_pc_r   [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_r;

  logic            credit_s;
  logic            grant_s;
  logic            resp_run_s;
  logic            pop_s;
  logic            bypass_s;
  logic            push_s;
  logic [31:0]     resp_pc_s;
  logic [31:0]     jump_tgt_s;
  logic [CW-1:0]   drop_jump_s;
  logic [CW-1:0]   outstanding_nxt_s;

  assign mem_addr_o = fpc_r;

  // Request/credit decode and the push/pop/bypass steering for this cycle
  always_comb begin
    credit_s          = ({1'b0, count_r} + {1'b0, outstanding_r}) < (CW + 1)'(FIFO_DEPTH);
    mem_req_o         = (state_r == RUN) && credit_s && !jump_i && !rst;
    grant_s           = mem_req_o && mem_gnt_i;
    resp_run_s        = mem_rvalid_i && (state_r == RUN) && !jump_i;
    pop_s             = !stall_i && !jump_i && (count_r != {CW{1'b0}});
    bypass_s          = resp_run_s && !stall_i && (count_r == {CW{1'b0}});
    push_s            = resp_run_s && !bypass_s;
    resp_pc_s         = rpc_r + 32'd4;
    jump_tgt_s        = {jump_addr_i[31:2], 2'b00};
    drop_jump_s       = outstanding_r - CW'(mem_rvalid_i);
    outstanding_nxt_s = outstanding_r + CW'(grant_s) - CW'(mem_rvalid_i);
  end

  // Buffer storage; each entry keeps the word and its decode-stage PC
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      buf_inst_r[wr_ptr_r] <= mem_rdata_i;
      buf_pc_r[wr_ptr_r]   <= resp_pc_s;
    end
  end

  // Fetch control state, counters and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      fpc_r         <= RESET_PC;
      rpc_r         <= RESET_PC;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      drop_r        <= {CW{1'b0}};
      pc_o          <= 32'd0;
      inst_o        <= 32'd0;
      inst_valid_o  <= 1'b0;
    end else if (jump_i) begin
      // Any response landing on the redirect edge is already accounted for in drop_jump_s
      outstanding_r <= outstanding_nxt_s;
      fpc_r         <= jump_tgt_s;
      rpc_r         <= jump_tgt_s;
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      drop_r        <= drop_jump_s;
      state_r       <= (drop_jump_s != {CW{1'b0}}) ? DRAIN : RUN;
      inst_o        <= 32'd0;
      inst_valid_o  <= 1'b0;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      if (grant_s) fpc_r <= fpc_r + 32'd4;
      if (resp_run_s) rpc_r <= resp_pc_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
      case (state_r)
        DRAIN: begin
          if (mem_rvalid_i) begin
            drop_r <= drop_r - CW'(1);
            if (drop_r <= CW'(1)) state_r <= RUN;
          end
        end
        default: state_r <= RUN;
      endcase
      if (!stall_i) begin
        if (pop_s) begin
          pc_o         <= buf_pc_r[rd_ptr_r];
          inst_o       <= buf_inst_r[rd_ptr_r];
          inst_valid_o <= 1'b1;
        end else if (bypass_s) begin
          pc_o         <= resp_pc_s;
          inst_o       <= mem_rdata_i;
          inst_valid_o <= 1'b1;
        end else begin
          inst_o       <= 32'd0;
          inst_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch unit for the in-order RV32I pipeline; feeds the IF/ID register that drives the decoder.
- Holds the fetch PC and issues in-order word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents one instruction per cycle downstream.
- Accepts redirect requests (jump/taken branch) from the decode stage and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding memory reads (power of 2, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset (compares against `RstEnable)
stall_i  input  1  downstream stall; holds output register
jump_i  input  1  redirect request from decode
jump_addr_i  input  32  redirect target; bits[1:0] forced to 0 internally
mem_req_o  output  1  read request to instruction memory
mem_addr_o  output  32  word address of the request
mem_gnt_i  input  1  request accepted this cycle (req & gnt)
mem_rvalid_i  input  1  read data valid; responses return in order, >=1 cycle after grant
mem_rdata_i  input  32  instruction word
pc_o  output  32  fetched address + 4 (decode-stage PC convention)
inst_o  output  32  instruction word; 0 when invalid
inst_valid_o  output  1  pc_o/inst_o hold a valid instruction

Behaviour:
- Reset (rst=1 at clk edge):
  - fpc <= RESET_PC; FIFO empty; outstanding=0; drop=0; state <= RUN.
  - pc_o, inst_o <= 0; inst_valid_o <= 0.
  - mem_req_o is 0 while rst is high.
- Reset mid-operation: all in-flight responses are forgotten; any mem_rvalid_i during or after reset for pre-reset requests is the memory's responsibility (the bench must not send them).
- States:
  - RUN: normal fetch.
  - DRAIN: discard `drop` pending responses after a redirect; no new requests.
  - DRAIN -> RUN when drop reaches 0, or when drop is 0 at redirect time (in which case DRAIN is skipped).
- Credit: credit = (fifo_count + outstanding) < FIFO_DEPTH.
- Request: mem_req_o = (state==RUN) & credit & !jump_i & !rst (combinational); mem_addr_o = fpc.
- On req & gnt: fpc <= fpc+4; outstanding++.
- Response in RUN: on rvalid, outstanding--; the word (with its address) is pushed to the FIFO.
  - Bypass: when the FIFO is empty and !stall_i, the word goes straight to the output register in the same edge (latency grant->inst_valid_o = 2 cycles when rvalid is 1 cycle after grant).
- Response in DRAIN: on rvalid, outstanding--, drop--, and the word is dropped.
- Output register:
  - When !stall_i: load the FIFO head (pop), else the bypass word, else inst_valid_o <= 0 and inst_o <= 0.
  - When stall_i: hold all output values.
- Redirect (jump_i=1), which has priority over stall_i and any response in the same cycle:
  - fpc <= {jump_addr_i[31:2],2'b00}; FIFO flushed.
  - inst_valid_o <= 0 and inst_o <= 0 on that edge.
  - drop <= outstanding minus (1 if rvalid same cycle, else 0); a response arriving on the jump cycle is discarded.
  - state <= DRAIN if the new drop > 0, else RUN.
  - No request is issued in the jump cycle.
  - A second jump_i while in DRAIN retargets fpc and recomputes drop the same way.
- Full FIFO with stall_i held: credit prevents overflow; a push and a pop in the same cycle leave the count unchanged.
- Throughput: gnt=1 and 1-cycle rvalid give one valid instruction per cycle in steady state.
- fpc wraps modulo 2^32 without error.

Test Plan:
- Reset, then gnt=1, rvalid 1 cycle after grant, mem returns addr as data:
  - mem_addr_o = 0,4,8,...
  - inst_valid_o first high 2 cycles after reset release with pc_o=4, inst_o=0.
  - pc_o increments by 4 every cycle afterwards.
- stall_i high 4 cycles mid-stream:
  - outputs frozen.
  - mem_req_o drops once 2 entries are buffered.
  - After release, sequence resumes with no lost or duplicated pc_o.
- jump_i=1, jump_addr_i=32'h100, with 1 outstanding read:
  - The stale response is dropped and inst_valid_o is 0 for that cycle.
  - Next request has addr 0x100; next valid has pc_o=0x104.
- jump_addr_i=32'h203:
  - mem_addr_o = 0x200.
- Jump on the same cycle as rvalid and stall_i=1:
  - The response is discarded, the output goes invalid, and there is no DRAIN when outstanding=1.
- Two back-to-back jumps (0x40, then 0x80) during DRAIN:
  - Only 0x80-path instructions appear; all counters return to 0 when idle.
